// File: rtl/instr_encoder_if.sv
// rtl/instr_encoder_if.sv - request and encoded-word handshake bundle for instr_encoder
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_class;
  logic [3:0]  in_alu_op;
  logic [2:0]  in_mask;
  logic [2:0]  in_br_type;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;

  modport master (
    output in_valid, in_class, in_alu_op, in_mask, in_br_type,
           in_rd, in_rs1, in_rs2, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_addr
  );

  modport slave (
    input  in_valid, in_class, in_alu_op, in_mask, in_br_type,
           in_rd, in_rs1, in_rs2, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_addr
  );
endinterface

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - RV32I instruction encoder with address tagging and output FIFO
module instr_encoder #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  instr_encoder_if.slave           bus,
  output logic                     err,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int             AW        = $clog2(DEPTH);
  localparam logic [AW:0]    DEPTH_CNT = (AW+1)'(DEPTH);

  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] word;
  logic        illegal;
  logic        shamt_op;

  always_comb begin
    f3 = 3'b000;
    case (bus.in_alu_op)
      4'd1:       f3 = 3'b001;
      4'd2:       f3 = 3'b010;
      4'd3:       f3 = 3'b011;
      4'd4:       f3 = 3'b100;
      4'd5, 4'd6: f3 = 3'b101;
      4'd7:       f3 = 3'b110;
      4'd8:       f3 = 3'b111;
      default:    f3 = 3'b000;
    endcase
    f7       = (bus.in_alu_op == 4'd9 || bus.in_alu_op == 4'd6) ? 7'b0100000 : 7'b0000000;
    shamt_op = (bus.in_alu_op == 4'd1 || bus.in_alu_op == 4'd5 || bus.in_alu_op == 4'd6);
    illegal  = (bus.in_alu_op > 4'd9);
    word     = '0;
    case (bus.in_class)
      4'd0: word = {f7, bus.in_rs2, bus.in_rs1, f3, bus.in_rd, 7'b0110011};
      4'd1: begin
        if (shamt_op)
          word = {f7, bus.in_imm[4:0], bus.in_rs1, f3, bus.in_rd, 7'b0010011};
        else
          word = {bus.in_imm[11:0], bus.in_rs1, f3, bus.in_rd, 7'b0010011};
        if (bus.in_alu_op == 4'd9) illegal = 1'b1;
      end
      4'd2: begin
        word = {bus.in_imm[11:0], bus.in_rs1, bus.in_mask, bus.in_rd, 7'b0000011};
        if (bus.in_mask == 3'd3 || bus.in_mask == 3'd6 || bus.in_mask == 3'd7) illegal = 1'b1;
      end
      4'd3: begin
        word = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_mask,
                bus.in_imm[4:0], 7'b0100011};
        if (bus.in_mask > 3'd2) illegal = 1'b1;
      end
      4'd4: begin
        word = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_br_type,
                bus.in_imm[4:1], bus.in_imm[11], 7'b1100011};
        if (bus.in_br_type == 3'd2 || bus.in_br_type == 3'd3) illegal = 1'b1;
      end
      4'd5: word = {bus.in_imm[31:12], bus.in_rd, 7'b0110111};
      4'd6: word = {bus.in_imm[31:12], bus.in_rd, 7'b0010111};
      4'd7: word = {bus.in_imm[20], bus.in_imm[10:1], bus.in_imm[11], bus.in_imm[19:12],
                    bus.in_rd, 7'b1101111};
      4'd8: word = {bus.in_imm[11:0], bus.in_rs1, 3'b000, bus.in_rd, 7'b1100111};
      default: illegal = 1'b1;
    endcase
  end

  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   addr_mem  [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [31:0]   wr_addr_q, wr_addr_d;
  logic          err_q, err_d;
  logic          accept, push, pop;

  assign bus.in_ready  = (count_q < DEPTH_CNT) && !clr;
  assign bus.out_valid = (count_q != '0);
  assign bus.out_instr = bus.out_valid ? instr_mem[rd_ptr_q] : '0;
  assign bus.out_addr  = bus.out_valid ? addr_mem[rd_ptr_q]  : '0;
  assign err           = err_q;
  assign count         = count_q;

  // Illegal requests are consumed but never reach the FIFO or the address counter.
  assign accept = bus.in_valid && bus.in_ready;
  assign push   = accept && !illegal;
  assign pop    = bus.out_valid && bus.out_ready && !clr;

  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    wr_addr_d = wr_addr_q;
    err_d     = err_q;
    if (clr) begin
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
      count_d   = '0;
      wr_addr_d = BASE_ADDR;
      err_d     = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d  = wr_ptr_q + 1'b1;
        wr_addr_d = wr_addr_q + 32'd4;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (accept && illegal) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      wr_addr_q <= BASE_ADDR;
      err_q     <= 1'b0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      wr_addr_q <= wr_addr_d;
      err_q     <= err_d;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= word;
      addr_mem[wr_ptr_q]  <= wr_addr_q;
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - randomized and directed self-checking bench for instr_encoder
module tb_instr_encoder;
  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       err;
  logic [2:0] count;

  instr_encoder_if ifc();

  instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (ifc),
    .err   (err),
    .count (count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic [3:0]  cls;
    logic [3:0]  op;
    logic [2:0]  mask;
    logic [2:0]  br;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        ordy;
    logic        c;
  } req_t;

  int checks = 0;
  int failures = 0;

  logic [31:0] mq_i [$];
  logic [31:0] mq_a [$];
  logic [31:0] m_addr;
  bit          m_err;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h @%0t", n, act, exp, $time);
    end
  endtask

  function automatic logic [32:0] ref_enc(input req_t r);
    int          f3_tab [10] = '{0, 1, 2, 3, 4, 5, 5, 6, 7, 0};
    logic [31:0] i, w, f3, f7, rd, rs1, rs2, mk, bt;
    bit          bad;
    i   = r.imm;
    rd  = 32'(r.rd);
    rs1 = 32'(r.rs1);
    rs2 = 32'(r.rs2);
    mk  = 32'(r.mask);
    bt  = 32'(r.br);
    f3  = (r.op <= 9) ? 32'(f3_tab[r.op]) : 32'h0;
    f7  = (r.op == 9 || r.op == 6) ? 32'h20 : 32'h0;
    bad = (r.cls > 8) || (r.op > 9) || (r.cls == 1 && r.op == 9) ||
          (r.cls == 2 && (r.mask == 3 || r.mask >= 6)) ||
          (r.cls == 3 && r.mask > 2) || (r.cls == 4 && (r.br == 2 || r.br == 3));
    w = 32'h0;
    case (r.cls)
      0: w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h33;
      1: if (r.op == 1 || r.op == 5 || r.op == 6)
           w = (f7 << 25) | ((i & 32'h1f) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
         else
           w = ((i & 32'hfff) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
      2: w = ((i & 32'hfff) << 20) | (rs1 << 15) | (mk << 12) | (rd << 7) | 32'h03;
      3: w = (((i >> 5) & 32'h7f) << 25) | (rs2 << 20) | (rs1 << 15) | (mk << 12) |
             ((i & 32'h1f) << 7) | 32'h23;
      4: w = (((i >> 12) & 32'h1) << 31) | (((i >> 5) & 32'h3f) << 25) | (rs2 << 20) |
             (rs1 << 15) | (bt << 12) | (((i >> 1) & 32'hf) << 8) |
             (((i >> 11) & 32'h1) << 7) | 32'h63;
      5: w = (i & 32'hfffff000) | (rd << 7) | 32'h37;
      6: w = (i & 32'hfffff000) | (rd << 7) | 32'h17;
      7: w = (((i >> 20) & 32'h1) << 31) | (((i >> 1) & 32'h3ff) << 21) |
             (((i >> 11) & 32'h1) << 20) | (i & 32'h000ff000) | (rd << 7) | 32'h6f;
      8: w = ((i & 32'hfff) << 20) | (rs1 << 15) | (rd << 7) | 32'h67;
      default: w = 32'h0;
    endcase
    return {bad, w};
  endfunction

  function automatic req_t rq(input int cls, input int op, input int mask, input int br,
                              input int rd, input int rs1, input int rs2,
                              input logic [31:0] imm, input bit ordy);
    req_t r;
    r.v = 1'b1; r.cls = 4'(cls); r.op = 4'(op); r.mask = 3'(mask); r.br = 3'(br);
    r.rd = 5'(rd); r.rs1 = 5'(rs1); r.rs2 = 5'(rs2); r.imm = imm; r.ordy = ordy; r.c = 1'b0;
    return r;
  endfunction

  function automatic req_t idle_r(input bit ordy);
    req_t r = '0;
    r.ordy = ordy;
    return r;
  endfunction

  function automatic req_t clr_r();
    req_t r = '0;
    r.c = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    mq_i.delete();
    mq_a.delete();
    m_addr = BASE;
    m_err  = 1'b0;
  endtask

  task automatic compare();
    chk("out_valid", 32'(ifc.out_valid), 32'(mq_i.size() > 0));
    chk("count", 32'(count), 32'(mq_i.size()));
    chk("err", 32'(err), 32'(m_err));
    chk("in_ready", 32'(ifc.in_ready), 32'(mq_i.size() < DEPTH && !clr));
    if (mq_i.size() > 0) begin
      chk("out_instr", ifc.out_instr, mq_i[0]);
      chk("out_addr", ifc.out_addr, mq_a[0]);
    end
  endtask

  task automatic step(input req_t r);
    logic [32:0] e;
    ifc.in_valid = r.v;   ifc.in_class = r.cls;  ifc.in_alu_op = r.op;
    ifc.in_mask = r.mask; ifc.in_br_type = r.br; ifc.in_rd = r.rd;
    ifc.in_rs1 = r.rs1;   ifc.in_rs2 = r.rs2;    ifc.in_imm = r.imm;
    ifc.out_ready = r.ordy;
    clr = r.c;
    if (r.c) begin
      model_reset();
    end else begin
      bit acc;
      acc = r.v && (mq_i.size() < DEPTH);
      if (r.ordy && mq_i.size() > 0) begin
        void'(mq_i.pop_front());
        void'(mq_a.pop_front());
      end
      if (acc) begin
        e = ref_enc(r);
        if (e[32]) m_err = 1'b1;
        else begin
          mq_i.push_back(e[31:0]);
          mq_a.push_back(m_addr);
          m_addr = m_addr + 32'd4;
        end
      end
    end
    @(negedge clk);
    compare();
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(ifc.out_valid), 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [32:0] pin;
    req_t        r;
    model_reset();
    ifc.in_valid = 1'b0; ifc.in_class = '0; ifc.in_alu_op = '0; ifc.in_mask = '0;
    ifc.in_br_type = '0; ifc.in_rd = '0; ifc.in_rs1 = '0; ifc.in_rs2 = '0;
    ifc.in_imm = '0; ifc.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_out_valid", 32'(ifc.out_valid), 32'h0);
    chk("reset_count", 32'(count), 32'h0);
    chk("reset_err", 32'(err), 32'h0);
    chk("reset_out_instr", ifc.out_instr, 32'h0);
    chk("reset_out_addr", ifc.out_addr, 32'h0);
    rst_n = 1'b1;
    step(idle_r(1'b0));
    chk("reset_in_ready", 32'(ifc.in_ready), 32'h1);

    pin = ref_enc(rq(0, 0, 0, 0, 3, 1, 2, 32'h0, 1'b0));        chk("pin_add", pin[31:0], 32'h002081B3);
    pin = ref_enc(rq(0, 9, 0, 0, 5, 6, 7, 32'h0, 1'b0));        chk("pin_sub", pin[31:0], 32'h407302B3);
    pin = ref_enc(rq(1, 0, 0, 0, 1, 0, 0, 32'hFFFFFFFF, 1'b0)); chk("pin_addi", pin[31:0], 32'hFFF00093);
    pin = ref_enc(rq(4, 0, 0, 0, 0, 1, 2, 32'h8, 1'b0));        chk("pin_beq", pin[31:0], 32'h00208463);
    pin = ref_enc(rq(7, 0, 0, 0, 1, 0, 0, 32'h800, 1'b0));      chk("pin_jal", pin[31:0], 32'h001000EF);
    pin = ref_enc(rq(1, 6, 0, 0, 2, 3, 0, 32'h5, 1'b0));        chk("pin_srai", pin[31:0], 32'h4051D113);
    pin = ref_enc(rq(3, 0, 2, 0, 0, 2, 3, 32'h14, 1'b0));       chk("pin_sw", pin[31:0], 32'h00312A23);
    pin = ref_enc(rq(5, 0, 0, 0, 5, 0, 0, 32'h12345000, 1'b0)); chk("pin_lui", pin[31:0], 32'h123452B7);
    pin = ref_enc(rq(1, 9, 0, 0, 1, 0, 0, 32'h0, 1'b0));        chk("pin_illegal", 32'(pin[32]), 32'h1);

    step(rq(0, 0, 0, 0, 3, 1, 2, 32'h0, 1'b1));
    chk("add_instr", ifc.out_instr, 32'h002081B3);
    chk("add_addr", ifc.out_addr, 32'h0);
    step(idle_r(1'b1));

    step(clr_r());
    step(rq(0, 9, 0, 0, 5, 6, 7, 32'h0, 1'b0));
    step(rq(1, 0, 0, 0, 1, 0, 0, 32'hFFFFFFFF, 1'b0));
    chk("sub_instr", ifc.out_instr, 32'h407302B3);
    chk("sub_addr", ifc.out_addr, 32'h0);
    step(idle_r(1'b1));
    chk("addi_instr", ifc.out_instr, 32'hFFF00093);
    chk("addi_addr", ifc.out_addr, 32'h4);
    step(idle_r(1'b1));

    step(clr_r());
    step(rq(4, 0, 0, 0, 0, 1, 2, 32'h8, 1'b1));
    chk("beq_instr", ifc.out_instr, 32'h00208463);
    step(rq(7, 0, 0, 0, 1, 0, 0, 32'h800, 1'b1));
    chk("jal_instr", ifc.out_instr, 32'h001000EF);
    chk("jal_addr", ifc.out_addr, 32'h4);
    step(idle_r(1'b1));

    step(clr_r());
    for (int k = 0; k < 4; k++) step(rq(1, 0, 0, 0, k + 1, 0, 0, 32'(k), 1'b0));
    chk("full_count", 32'(count), 32'h4);
    chk("full_in_ready", 32'(ifc.in_ready), 32'h0);
    step(rq(1, 0, 0, 0, 9, 0, 0, 32'h9, 1'b0));
    chk("full_count_hold", 32'(count), 32'h4);
    for (int k = 0; k < 4; k++) begin
      chk("drain_addr", ifc.out_addr, 32'(4 * k));
      step(idle_r(1'b1));
    end

    step(clr_r());
    step(rq(0, 0, 0, 0, 1, 2, 3, 32'h0, 1'b0));
    step(rq(1, 9, 0, 0, 1, 0, 0, 32'h0, 1'b0));
    chk("illegal_err", 32'(err), 32'h1);
    chk("illegal_count", 32'(count), 32'h1);
    step(rq(0, 4, 0, 0, 4, 5, 6, 32'h0, 1'b0));
    step(idle_r(1'b1));
    chk("post_illegal_addr", ifc.out_addr, 32'h4);
    step(clr_r());
    chk("clr_err", 32'(err), 32'h0);
    chk("clr_count", 32'(count), 32'h0);
    step(rq(8, 0, 0, 0, 1, 2, 0, 32'h10, 1'b0));
    chk("clr_next_addr", ifc.out_addr, BASE);

    step(rq(2, 0, 7, 0, 1, 1, 0, 32'h0, 1'b0));
    step(rq(6, 0, 0, 0, 2, 0, 0, 32'hABCDE123, 1'b0));
    step(rq(3, 0, 1, 0, 0, 3, 4, 32'hFFFFFFF0, 1'b0));
    chk("pre_reset_count", 32'(count), 32'h3);
    async_reset();

    for (int n = 0; n < 3000; n++) begin
      r.v    = ($urandom_range(0, 9) < 7);
      r.cls  = ($urandom_range(0, 99) < 90) ? 4'($urandom_range(0, 8)) : 4'($urandom_range(9, 15));
      r.op   = ($urandom_range(0, 99) < 90) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(10, 15));
      r.mask = 3'($urandom_range(0, 7));
      r.br   = 3'($urandom_range(0, 7));
      r.rd   = 5'($urandom);
      r.rs1  = 5'($urandom);
      r.rs2  = 5'($urandom);
      r.imm  = $urandom;
      r.ordy = ($urandom_range(0, 9) < 6);
      r.c    = ($urandom_range(0, 59) == 0);
      step(r);
      if (n == 1500) async_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4, meaning output FIFO entries (power of two, at least 2).
REQ-002 The module SHALL have parameter BASE_ADDR, default 32'h0, meaning the first byte address tagged on encoded words.
REQ-003 The module SHALL have one clock; reset is asynchronous and active-low.
REQ-004 The ports SHALL be as follows, one per line (name  direction  width  meaning):
  clk  in  1  rising-edge clock
  rst_n  in  1  asynchronous active-low reset
  clr  in  1  synchronous flush/restart
  in_valid  in  1  request valid
  in_ready  out  1  request accepted when in_valid&&in_ready
  in_class  in  4  0 R, 1 I-ALU, 2 LOAD, 3 STORE, 4 BRANCH, 5 LUI, 6 AUIPC, 7 JAL, 8 JALR, 9-15 illegal
  in_alu_op  in  4  0 ADD,1 SLL,2 SLT,3 SLTU,4 XOR,5 SRL,6 SRA,7 OR,8 AND,9 SUB
  in_mask  in  3  load/store width funct3
  in_br_type  in  3  branch funct3
  in_rd, in_rs1, in_rs2  in  5 each  register indices
  in_imm  in  32  signed immediate, byte offset
  out_valid  out  1  encoded word available
  out_ready  in  1  consumer accepts
  out_instr  out  32  RV32I instruction word
  out_addr  out  32  byte address of out_instr
  err  out  1  sticky illegal-request flag
  count  out  $clog2(DEPTH)+1  FIFO occupancy

Function
REQ-005 Opcodes SHALL be: R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111.
REQ-006 The alu_op to funct3 mapping SHALL be: 0/9 to 000, 1 to 001, 2 to 010, 3 to 011, 4 to 100, 5/6 to 101, 7 to 110, 8 to 111; funct7 SHALL be 0100000 for op 9 (R) and op 6, otherwise 0000000.
REQ-007 Field placement SHALL be:
  rd at [11:7]; rs1 at [19:15]; rs2 at [24:20]; funct3 at [14:12].
  I-ALU, LOAD, JALR: [31:20]=imm[11:0]; for alu_op 1/5/6, [24:20]=imm[4:0] and [31:25]=funct7.
  LOAD funct3=in_mask; JALR funct3=000.
  STORE: [31:25]=imm[11:5], [11:7]=imm[4:0], funct3=in_mask.
  BRANCH: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11], funct3=in_br_type.
  LUI/AUIPC: [31:12]=imm[31:12].
  JAL: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
  All fields unused by a format SHALL be zero.
REQ-008 The following requests SHALL be illegal: class 9-15; alu_op above 9; alu_op 9 with I-ALU; LOAD mask in {3,6,7}; STORE mask above 2; BRANCH br_type 2 or 3.
REQ-009 An illegal request SHALL still be accepted, SHALL NOT be enqueued, SHALL NOT advance the address, and SHALL set err to 1 on the next edge.
REQ-010 Legal accepted requests SHALL be encoded and pushed into the FIFO with the current wr_addr; wr_addr SHALL then advance by 4, wrapping modulo 2^32.
REQ-011 in_ready SHALL equal (count<DEPTH) && !clr; no same-cycle bypass when full.
REQ-012 Latency SHALL be one cycle: a push at edge N SHALL make out_valid=1 after edge N when the FIFO was empty.
REQ-013 out_instr and out_addr SHALL present the FIFO head and SHALL remain stable while out_valid && !out_ready.
REQ-014 A simultaneous push and pop SHALL leave count unchanged; FIFO pointers SHALL wrap at DEPTH.
REQ-015 clr SHALL take priority over everything: FIFO emptied, wr_addr=BASE_ADDR, err=0, and no pop counted in that cycle.

Reset
REQ-016 When rst_n=0, in any state or mid-transfer, the module SHALL set out_valid=0, count=0, err=0, wr_addr=BASE_ADDR, out_instr=0, out_addr=0, and in_ready=1 from the first edge after release.

Verification
REQ-017 R ADD: rd=3, rs1=1, rs2=2 -> out_instr=0x002081B3, out_addr=0x0, one cycle after accept.
REQ-018 R SUB then I-ALU ADDI: SUB rd=5, rs1=6, rs2=7, then ADDI rd=1, rs1=0, imm=-1 -> 0x407302B3 @0x0, then 0xFFF00093 @0x4.
REQ-019 BEQ then JAL: BEQ rs1=1, rs2=2, imm=8 -> 0x00208463; JAL rd=1, imm=0x800 -> 0x001000EF.
REQ-020 Backpressure: out_ready=0 with 5 legal requests -> count=4, in_ready=0 on the 5th; release out_ready -> 4 words pop in order with addresses 0x0,0x4,0x8,0xC.
REQ-021 Illegal and clear: I-ALU with alu_op 9 -> err=1, count unchanged, next legal word gets the prior address; clr pulse -> err=0, count=0, next address=BASE_ADDR.
REQ-022 Reset mid-operation: rst_n low with 3 entries queued -> out_valid=0, count=0, err=0 asynchronously.
